// File: rtl/pipo_share_arbiter_pkg.sv
// pipo_share_arbiter_pkg
//   Shared definitions for the PIPO share arbiter slice:
//   - FSM state encoding (IDLE/LOAD/HOLD/RELEASE)
//   - log2c(): ceiling log2 used to size index and counter fields
package pipo_share_arbiter_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] LOAD    = 2'd1;
    localparam logic [1:0] HOLD    = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    // Ceiling log2 with a floor of 1 so a field is never zero bits wide.
    function automatic int log2c(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/pipo_share_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin search: returns the first set req bit found
//   searching upward from ptr, wrapping from N_REQ-1 back to 0.
// Ports:
//   req  in  N_REQ  request vector
//   ptr  in  PW     search start index
//   any  out 1      at least one request bit is set
//   idx  out PW     index of the winner (0 when any=0)
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic             any,
    output logic [PW-1:0]    idx
);

    logic [PW-1:0] cand;

    // N_REQ is a power of two, so the PW-bit add wraps exactly at N_REQ.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = ptr + PW'(i);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/pipo_share_arbiter.sv
// pipo_share_arbiter
//   N_REQ requesters share one WIDTH-bit parallel-in/parallel-out register.
//   A round-robin FSM grants one requester at a time; the grantee's data
//   slice is loaded once (LOAD), then the grant is held (HOLD) until the
//   requester drops req or, under contention, HOLD_MAX hold cycles elapse.
//   Every grant is followed by RELEASE and IDLE, both with gnt all-zero.
//
//   Handshake: req[i] is a level held by requester i until it is done;
//   gnt[i] high means requester i owns the register. A requester that sees
//   gnt drop must not assume ownership again until gnt[i] rises anew.
// Ports:
//   clk        in  1            rising-edge clock
//   rst_n      in  1            synchronous active-low reset
//   req        in  N_REQ        per-requester request levels
//   d          in  N_REQ*WIDTH  write data, requester i at [i*WIDTH +: WIDTH]
//   gnt        out N_REQ        one-hot grant (zero in IDLE/RELEASE)
//   owner      out log2(N_REQ)  current or most recent grantee
//   q          out WIDTH        register contents
//   valid      out 1            q loaded at least once since reset
//   busy       out 1            FSM not in IDLE
//   dbg_state  out 2            current FSM state for observation
module pipo_share_arbiter
    import pipo_share_arbiter_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 4,
    parameter int HOLD_MAX = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*WIDTH-1:0]      d,
    output logic [N_REQ-1:0]            gnt,
    output logic [log2c(N_REQ)-1:0]     owner,
    output logic [WIDTH-1:0]            q,
    output logic                        valid,
    output logic                        busy,
    output logic [1:0]                  dbg_state
);

    localparam int PW = log2c(N_REQ);
    localparam int CW = log2c(HOLD_MAX);
    localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_MAX - 1);

    logic [1:0]       state;
    logic [PW-1:0]    ptr;
    logic [CW-1:0]    cnt;
    logic             pick_any;
    logic [PW-1:0]    pick_idx;
    logic [N_REQ-1:0] own_mask;
    logic             others;
    logic             owner_req;
    logic             load_en;

    rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_rr_pick (
        .req (req),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_comb begin
        own_mask  = N_REQ'(1) << owner;
        owner_req = req[owner];
        // Contention means someone other than the owner is waiting.
        others    = |(req & ~own_mask);
        load_en   = (state == LOAD);
    end

    // Grant is decoded from registered state and owner only (Moore).
    assign gnt       = (state == LOAD || state == HOLD) ? own_mask : '0;
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        owner <= pick_idx;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    // Completes regardless of req[owner] so q is always written.
                    cnt   <= '0;
                    state <= HOLD;
                end
                HOLD: begin
                    if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
                    if (!owner_req) begin
                        state <= RELEASE;
                    end else if (cnt == CNT_MAX && others) begin
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    // Next search starts just past the outgoing owner.
                    ptr   <= owner + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Shared storage: written only on the edge that leaves LOAD.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q     <= '0;
            valid <= 1'b0;
        end else if (load_en) begin
            q     <= d[int'(owner)*WIDTH +: WIDTH];
            valid <= 1'b1;
        end
    end

endmodule

// File: doc/pipo_share_arbiter.md
PIPO_SHARE_ARBITER -- requirements
Module: pipo_share_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the register (power of two, 2..8).
REQ-002 Parameter WIDTH, default 4: register width in bits.
REQ-003 Parameter HOLD_MAX, default 8: HOLD cycles after which a contested grant is pre-empted (>=2).
REQ-004 The block SHALL have one clock and a synchronous, active-low reset.
REQ-005 clk  input  1  the only clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
REQ-007 req  input  N_REQ  per-requester access request, level-held until done.
REQ-008 d  input  N_REQ*WIDTH  write data; requester i uses bits [i*WIDTH +: WIDTH].
REQ-009 gnt  output  N_REQ  one-hot grant, all-zero when no owner.
REQ-010 owner  output  clog2(N_REQ)  index of the current or most recent grantee.
REQ-011 q  output  WIDTH  parallel-out register contents.
REQ-012 valid  output  1  high once q has been loaded at least once since reset.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, LOAD, HOLD, RELEASE.
REQ-015 IDLE: gnt=0; if any req bit is high, the next state is LOAD and owner takes the round-robin winner; otherwise remain in IDLE.
REQ-016 Round-robin winner: first set req bit searching upward from pointer ptr, wrapping from N_REQ-1 to 0.
REQ-017 gnt SHALL be Moore-decoded: gnt[owner]=1 in LOAD and HOLD, all-zero in IDLE and RELEASE.
REQ-018 Latency: a req first sampled high in IDLE at edge k SHALL give gnt high after edge k, and q updated after edge k+1.
REQ-019 LOAD: on the exiting edge, q takes the owner's d slice, valid sets to 1, hold counter clears to 0, and the next state is HOLD.
REQ-020 The LOAD always completes, even if req[owner] falls during LOAD.
REQ-021 HOLD: q is unchanged and the counter increments, saturating at HOLD_MAX-1.
REQ-022 HOLD exit on release: if req[owner]=0, the next state is RELEASE.
REQ-023 HOLD exit on pre-emption: if req[owner]=1, counter==HOLD_MAX-1 and another req bit is set, the next state is RELEASE.
REQ-024 HOLD with no contention: if req[owner]=1 and no other req bit is set, remain in HOLD indefinitely.
REQ-025 RELEASE: one gap cycle with gnt=0; ptr takes (owner+1) mod N_REQ; the next state is IDLE.
REQ-026 Minimum spacing between two grants SHALL be two cycles with gnt all-zero (RELEASE then IDLE).
REQ-027 In IDLE, simultaneous requests SHALL be resolved only by ptr; lower index has no other priority.
REQ-028 owner and q SHALL retain their values through RELEASE and IDLE.
REQ-029 req bits of non-owners during LOAD/HOLD SHALL have no effect except enabling pre-emption.

Reset
REQ-030 On rst_n=0 at a rising edge: state=IDLE, gnt=0, owner=0, ptr=0, counter=0, q=0, valid=0, busy=0.
REQ-031 Reset asserted mid-LOAD or mid-HOLD SHALL abort with no load of q on that edge; reset takes priority over every transition.
REQ-032 First arbitration after reset release SHALL start from ptr=0.

Structure
REQ-033 A shared package SHALL hold the state encoding constants (IDLE=0, LOAD=1, HOLD=2, RELEASE=3) and the log2 helper function.
REQ-034 The round-robin winner search SHALL be a separate combinational sub-module, rr_pick (inputs req, ptr; outputs any, idx).
REQ-035 The WIDTH-bit storage SHALL be a plain enabled register inside pipo_share_arbiter, loaded only in LOAD.

Verification
REQ-036 Single requester: req=4'b0100, d[11:8]=4'b1101 -> gnt=4'b0100 the next cycle, q=4'b1101 and valid=1 a cycle later; drop req -> RELEASE, IDLE, ptr=3.
REQ-037 All requesters at once: req=4'b1111 held, HOLD_MAX=8 -> grants rotate 0,1,2,3,0, each lasting 1 LOAD + 8 HOLD cycles, separated by 2 idle cycles.
REQ-038 Uncontested hold: req=4'b0001 held for 50 cycles -> gnt stays 4'b0001 throughout; no pre-emption; q loaded once.
REQ-039 Wrap-around: owner=3 releases while req=4'b1001 -> the next grant goes to 0, not 3.
REQ-040 Reset mid-HOLD: rst_n=0 for one edge during HOLD -> all outputs zero after that edge; q=0, valid=0; the next grant goes to the lowest set req bit.
REQ-041 Drop during LOAD: req[1] falls in the LOAD cycle -> q is still loaded with d[7:4], followed by one HOLD cycle, then RELEASE.
